// File: rtl/row_buf_writer.sv
// Write-side sequencer rotating a raster pixel stream across three row buffers for 3x3 convolution.
// Optional ROW_BUF_WRITER_STATS_EN adds drop_cnt/sync_err diagnostic outputs.
module row_buf_writer #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int PIX_W    = 12,
  parameter int NUM_ROWS = 3
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic [PIX_W-1:0]    pix_data,
  input  logic                pix_valid,
  input  logic                pix_sof,
  output logic                pix_ready,
  input  logic                conv_busy,
  output logic [NUM_ROWS-1:0] buf_wr_en,
  output logic [PIX_W-1:0]    buf_wr_data,
  output logic [NUM_ROWS-1:0] buf_clr,
  output logic [1:0]          wr_sel,
  output logic                row_done,
  output logic [8:0]          row_idx,
  output logic                win_start,
  output logic                frame_done
`ifdef ROW_BUF_WRITER_STATS_EN
  ,
  output logic [15:0]         drop_cnt,
  output logic                sync_err
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam int              COL_W    = $clog2(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [8:0]       ROW_LAST = 9'(IMG_H - 1);

  logic [1:0]          state;
  logic [COL_W-1:0]    col;
  logic [8:0]          row;
  logic                pend_vld;
  logic [PIX_W-1:0]    pend_data;

  logic                accept;
  logic                abort;
  logic                sof_start;
  logic [NUM_ROWS-1:0] sel_onehot;
  logic [1:0]          next_sel;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Ready depends on state alone so upstream never sees a valid->ready loop.
  assign pix_ready  = (state == S_IDLE) || (state == S_WRITE);
  assign accept     = pix_valid && pix_ready;
  assign sel_onehot = NUM_ROWS'(1) << wr_sel;
  assign next_sel   = (wr_sel == 2'd2) ? 2'd0 : wr_sel + 2'd1;
  assign buf_clr    = (state == S_CLEAR) ? sel_onehot : '0;

  // A sof anywhere past the very first slot of a frame restarts the frame.
  assign abort     = accept && pix_sof && (state == S_WRITE) &&
                     ((col != '0) || (row != '0));
  assign sof_start = accept && pix_sof && (state == S_IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (sof_start || abort) begin
      pend_data <= pix_data;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      col         <= '0;
      row         <= '0;
      wr_sel      <= 2'd0;
      pend_vld    <= 1'b0;
      buf_wr_en   <= '0;
      buf_wr_data <= '0;
      row_done    <= 1'b0;
      row_idx     <= '0;
      win_start   <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      buf_wr_en  <= '0;
      row_done   <= 1'b0;
      win_start  <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sof_start) begin
            state    <= S_CLEAR;
            row      <= '0;
            wr_sel   <= 2'd0;
            col      <= '0;
            pend_vld <= 1'b1;
          end
        end
        S_CLEAR: begin
          state <= S_WRITE;
          if (pend_vld) begin
            buf_wr_en   <= sel_onehot;
            buf_wr_data <= pend_data;
            col         <= COL_ONE;
            pend_vld    <= 1'b0;
          end
        end
        S_WRITE: begin
          if (abort) begin
            state    <= S_CLEAR;
            row      <= '0;
            wr_sel   <= 2'd0;
            col      <= '0;
            pend_vld <= 1'b1;
          end else if (accept) begin
            buf_wr_en   <= sel_onehot;
            buf_wr_data <= pix_data;
            if (col == COL_LAST) begin
              col       <= '0;
              row_done  <= 1'b1;
              row_idx   <= row;
              win_start <= (row >= 9'd2);
              if (row == ROW_LAST) begin
                frame_done <= 1'b1;
                state      <= S_IDLE;
                row        <= '0;
                wr_sel     <= 2'd0;
              end else begin
                row    <= row + 9'd1;
                wr_sel <= next_sel;
                state  <= S_WAIT;
              end
            end else begin
              col <= col + COL_ONE;
            end
          end
        end
        S_WAIT: begin
          // The first three rows never reuse a buffer the reader could hold.
          if ((row < 9'd3) || !conv_busy) begin
            state <= S_CLEAR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ROW_BUF_WRITER_STATS_EN
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      if (accept && !pix_sof && (state == S_IDLE)) begin
        drop_cnt <= sat_inc16(drop_cnt);
      end
      if (abort) begin
        sync_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_row_buf_writer.sv
// Directed bench for row_buf_writer: a scoreboard checks every buffer write and a
// linear stimulus sequence walks through drops, a full frame, backpressure, abort and reset.
module tb_row_buf_writer;

  localparam int IMG_W = 640;
  localparam int IMG_H = 8;

  logic        CLOCK_50 = 1'b0;
  logic        rst_n;
  logic [11:0] pix_data;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic        conv_busy;
  logic [2:0]  buf_wr_en;
  logic [11:0] buf_wr_data;
  logic [2:0]  buf_clr;
  logic [1:0]  wr_sel;
  logic        row_done;
  logic [8:0]  row_idx;
  logic        win_start;
  logic        frame_done;
`ifdef ROW_BUF_WRITER_STATS_EN
  logic [15:0] drop_cnt;
  logic        sync_err;
`endif

  row_buf_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(12), .NUM_ROWS(3)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_sof    (pix_sof),
    .pix_ready  (pix_ready),
    .conv_busy  (conv_busy),
    .buf_wr_en  (buf_wr_en),
    .buf_wr_data(buf_wr_data),
    .buf_clr    (buf_clr),
    .wr_sel     (wr_sel),
    .row_done   (row_done),
    .row_idx    (row_idx),
    .win_start  (win_start),
    .frame_done (frame_done)
`ifdef ROW_BUF_WRITER_STATS_EN
    ,
    .drop_cnt   (drop_cnt),
    .sync_err   (sync_err)
`endif
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [1:0]  bsel;
    logic [11:0] d;
  } exp_t;

  exp_t       exp_q[$];
  int         rd_log[$];
  int         clr_log[$];
  int         checks = 0;
  int         errors = 0;
  int         wr_cnt = 0;
  int         ws_cnt = 0;
  int         fd_cnt = 0;
  bit         expect_drop = 1'b0;
  bit         lat_pending = 1'b0;
  bit [2:0]   cleared = 3'b000;
  exp_t       mon_e;

  function automatic logic [2:0] oh(input logic [1:0] s);
    oh = 3'b001 << s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Present one pixel, wait for ready, and queue its expected write unless it should be dropped.
  task automatic send_pix(input logic [11:0] d, input bit sof, input int bsel, input bit drop);
    int guard;
    guard     = 0;
    pix_data  = d;
    pix_sof   = sof;
    pix_valid = 1'b1;
    while (!pix_ready && guard < 2000) begin
      step();
      guard++;
    end
    if (guard >= 2000) chk("ready_timeout", 32'd0, 32'd1);
    if (!drop) exp_q.push_back('{bsel: 2'(bsel), d: d});
    step();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_row(input int r, input int ncols, input logic [11:0] base, input bit sof_first);
    for (int c = 0; c < ncols; c++) begin
      send_pix(base + 12'(c), sof_first && (c == 0), r % 3, 1'b0);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (rst_n) begin
      if (buf_wr_en != 3'b000) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", 32'(buf_wr_en), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_en", 32'(buf_wr_en), 32'(oh(mon_e.bsel)));
          chk("wr_data", 32'(buf_wr_data), 32'(mon_e.d));
          chk("clr_before_wr", 32'(cleared[mon_e.bsel]), 32'd1);
          if (row_done) cleared[mon_e.bsel] = 1'b0;
        end
      end
      if (lat_pending) chk("wr_latency", 32'(buf_wr_en != 3'b000), 32'd1);
      if (buf_clr != 3'b000) begin
        clr_log.push_back(int'(wr_sel));
        chk("clr_sel", 32'(buf_clr), 32'(oh(wr_sel)));
        chk("clr_ready", 32'(pix_ready), 32'd0);
        cleared[wr_sel] = 1'b1;
      end
      if (row_done || win_start || frame_done) begin
        chk("rd_pulse", 32'(row_done), 32'd1);
        chk("rd_with_wr", 32'(buf_wr_en != 3'b000), 32'd1);
        chk("win_start", 32'(win_start), 32'(row_idx >= 9'd2));
        rd_log.push_back(int'(row_idx));
        if (win_start) ws_cnt++;
        if (frame_done) fd_cnt++;
      end
      lat_pending = pix_valid && pix_ready && !pix_sof && !expect_drop;
    end else begin
      lat_pending = 1'b0;
    end
  end

  initial begin
    int base;
    int cbase;
    int bad;
    rst_n     = 1'b0;
    pix_data  = '0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    conv_busy = 1'b0;
    repeat (3) step();

    chk("rst_ready", 32'(pix_ready), 32'd1);
    chk("rst_wr_en", 32'(buf_wr_en), 32'd0);
    chk("rst_clr", 32'(buf_clr), 32'd0);
    chk("rst_wr_sel", 32'(wr_sel), 32'd0);
    chk("rst_row_done", 32'(row_done), 32'd0);
    chk("rst_row_idx", 32'(row_idx), 32'd0);
    chk("rst_win_start", 32'(win_start), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    step();

    // Pixels without sof while idle are swallowed.
    expect_drop = 1'b1;
    for (int i = 0; i < 10; i++) send_pix(12'h100 + 12'(i), 1'b0, 0, 1'b1);
    expect_drop = 1'b0;
    repeat (3) step();
    chk("drop_no_write", 32'(wr_cnt), 32'd0);
    chk("drop_ready", 32'(pix_ready), 32'd1);
`ifdef ROW_BUF_WRITER_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'd10);
`endif

    // Full frame of ramp pixels, with reader backpressure before the first buffer reuse.
    for (int r = 0; r < IMG_H; r++) begin
      send_row(r, IMG_W, 12'((r * IMG_W) & 12'hFFF), r == 0);
      chk("row_done_now", 32'(row_done), 32'd1);
      chk("row_idx_now", 32'(row_idx), 32'(r));
      if (r == 0) begin
        chk("row0_wr_en", 32'(buf_wr_en), 32'h1);
        chk("row0_last_data", 32'(buf_wr_data), 32'h27F);
        chk("row0_win", 32'(win_start), 32'd0);
      end
      if (r == 2) begin
        chk("row2_win", 32'(win_start), 32'd1);
        conv_busy = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
          step();
          if (pix_ready || buf_clr != 3'b000) bad++;
        end
        chk("busy_stall", 32'(bad), 32'd0);
        conv_busy = 1'b0;
        step();
        chk("busy_release_clr", 32'(buf_clr), 32'h1);
        chk("busy_release_ready", 32'(pix_ready), 32'd0);
      end
      if (r == IMG_H - 1) chk("frame_done_now", 32'(frame_done), 32'd1);
      else                chk("frame_done_early", 32'(frame_done), 32'd0);
    end
    repeat (3) step();
    chk("f1_rd_count", 32'(rd_log.size()), 32'(IMG_H));
    for (int i = 0; i < IMG_H; i++) chk("f1_rd_idx", 32'(rd_log[i]), 32'(i));
    for (int i = 0; i < IMG_H; i++) chk("f1_clr_seq", 32'(clr_log[i]), 32'(i % 3));
    chk("f1_win_count", 32'(ws_cnt), 32'(IMG_H - 2));
    chk("f1_frame_done_count", 32'(fd_cnt), 32'd1);
    chk("f1_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("f1_idle_ready", 32'(pix_ready), 32'd1);

    // sof in the middle of row 5 restarts the frame in buffer 0.
    base  = rd_log.size();
    cbase = clr_log.size();
    for (int r = 0; r < 5; r++) send_row(r, IMG_W, 12'h400 + 12'(r * 16), r == 0);
    send_row(5, 100, 12'h800, 1'b0);
    send_pix(12'hABC, 1'b1, 0, 1'b0);
    chk("abort_clr", 32'(buf_clr), 32'h1);
    chk("abort_ready", 32'(pix_ready), 32'd0);
    chk("abort_no_rd", 32'(row_done), 32'd0);
    for (int c = 1; c < IMG_W; c++) send_pix(12'h200 + 12'(c), 1'b0, 0, 1'b0);
    chk("abort_row0_done", 32'(row_done), 32'd1);
    chk("abort_row0_idx", 32'(row_idx), 32'd0);
    chk("abort_row0_buf", 32'(buf_wr_en), 32'h1);
    chk("abort_no_frame_done", 32'(frame_done), 32'd0);
    step();
    chk("abort_rd_count", 32'(rd_log.size() - base), 32'd6);
    chk("abort_rd_last", 32'(rd_log[base + 5]), 32'd0);
    chk("abort_clr_seq", 32'(clr_log[cbase + 6]), 32'd0);
`ifdef ROW_BUF_WRITER_STATS_EN
    chk("sync_err_set", 32'(sync_err), 32'd1);
`endif

    // Reset in the middle of row 2, then a fresh frame.
    send_row(1, IMG_W, 12'h300, 1'b0);
    send_row(2, 300, 12'h600, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(pix_ready), 32'd1);
    chk("mid_rst_wr_en", 32'(buf_wr_en), 32'd0);
    chk("mid_rst_wr_data", 32'(buf_wr_data), 32'd0);
    chk("mid_rst_clr", 32'(buf_clr), 32'd0);
    chk("mid_rst_wr_sel", 32'(wr_sel), 32'd0);
    chk("mid_rst_row_idx", 32'(row_idx), 32'd0);
    chk("mid_rst_pulses", 32'({row_done, win_start, frame_done}), 32'd0);
    repeat (2) step();
    exp_q.delete();
    rst_n = 1'b1;
    step();
`ifdef ROW_BUF_WRITER_STATS_EN
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_sync_err", 32'(sync_err), 32'd0);
`endif
    base  = rd_log.size();
    cbase = clr_log.size();
    send_row(0, IMG_W, 12'h5A0, 1'b1);
    chk("new_row0_idx", 32'(row_idx), 32'd0);
    chk("new_row0_buf", 32'(buf_wr_en), 32'h1);
    send_row(1, IMG_W, 12'h0F0, 1'b0);
    chk("new_row1_idx", 32'(row_idx), 32'd1);
    chk("new_row1_buf", 32'(buf_wr_en), 32'h2);
    repeat (3) step();
    chk("new_rd_count", 32'(rd_log.size() - base), 32'd2);
    chk("new_clr_first", 32'(clr_log[cbase]), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
